// File: rtl/riscv_pkg.sv
// Shared definitions for the core's memory-side blocks.
//   SZ_BYTE / SZ_HALF / SZ_WORD : load/store access size encodings (11 is illegal)
//   arb_state_t                 : unified-memory arbiter state
package riscv_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,   // no access outstanding
        ST_RESP_IF = 2'b01,   // fetch read data arrives this cycle
        ST_RESP_DM = 2'b10    // data access completes (or is rejected) this cycle
    } arb_state_t;

endpackage

// File: rtl/be_gen.sv
// Byte-enable generator for data accesses.
// Ports:
//   size     in  2  access size (SZ_BYTE / SZ_HALF / SZ_WORD, 11 illegal)
//   offset   in  2  byte offset within the word (addr[1:0])
//   be       out 4  byte-lane enables, 0000 when the access is rejected
//   misalign out 1  access is misaligned for its size, or the size is illegal
module be_gen
    import riscv_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] be,
    output logic       misalign
);

    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: begin
                misalign = offset[0];
                be       = 4'b0011 << offset;
            end
            SZ_WORD: begin
                misalign = |offset;
                be       = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
        // A rejected access never reaches the memory, so its lanes stay dark.
        if (misalign) be = 4'b0000;
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported, synchronous-read unified memory between
// instruction fetch (IF) and load/store (DM). One access is granted per cycle;
// DM wins contention unless fetch has been denied MAX_STARVE cycles in a row.
//
// Handshake: x_req is a level held by the requester until its response
// (x_valid, or dm_err for DM). The response is a one-cycle pulse in the cycle
// after the grant. During a response cycle the requester's req is still seen
// and is treated as a new request, so a port can be granted every cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request, byte address ([1:0] ignored)
//   if_rdata/if_valid             fetched word, completion pulse
//   dm_req/dm_we/dm_size/dm_addr  data request, store flag, size, byte address
//   dm_wdata                      lane-aligned store data
//   dm_rdata/dm_valid/dm_err      raw loaded word, completion pulse, reject pulse
//   mem_en/mem_we/mem_be          memory strobe, write, byte enables
//   mem_addr/mem_wdata            word address, write data
//   mem_rdata                     memory read data, one cycle after mem_en
module imem_dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = $clog2(MAX_STARVE + 1);

    arb_state_t  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic        resp_err_q, resp_err_d;   // pending DM response is a reject
    logic        resp_ld_q, resp_ld_d;     // pending DM response is a load
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;

    logic [3:0]  dm_be;
    logic        dm_misalign;
    logic        starved;
    logic        dm_win;
    logic        if_win;

    // Fetch is word-granular; the byte offset is intentionally dropped.
    logic unused_if_offset;
    assign unused_if_offset = ^if_addr[1:0];

    be_gen u_be_gen (
        .size     (dm_size),
        .offset   (dm_addr[1:0]),
        .be       (dm_be),
        .misalign (dm_misalign)
    );

    // A rejected DM request still occupies the slot, so fetch loses that cycle.
    assign starved = (starve_q == SW'(MAX_STARVE));
    assign dm_win  = dm_req && !(if_req && starved);
    assign if_win  = if_req && !dm_win;

    always_comb begin
        state_d    = ST_IDLE;
        starve_d   = starve_q;
        resp_err_d = 1'b0;
        resp_ld_d  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = 32'h0;

        if (!rst) begin
            if (dm_win) begin
                state_d    = ST_RESP_DM;
                resp_err_d = dm_misalign;
                resp_ld_d  = !dm_we;
                if (!dm_misalign) begin
                    mem_en    = 1'b1;
                    mem_we    = dm_we;
                    mem_be    = dm_be;
                    mem_addr  = dm_addr[ADDR_W-1:2];
                    mem_wdata = dm_we ? dm_wdata : 32'h0;
                end
            end else if (if_win) begin
                state_d  = ST_RESP_IF;
                mem_en   = 1'b1;
                mem_be   = 4'b1111;
                mem_addr = if_addr[ADDR_W-1:2];
            end
        end

        if (!if_req || if_win) begin
            starve_d = '0;
        end else if (dm_win && !starved) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            resp_err_q <= 1'b0;
            resp_ld_q  <= 1'b0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            resp_err_q <= resp_err_d;
            resp_ld_q  <= resp_ld_d;
            if (state_q == ST_RESP_IF) begin
                if_rdata_q <= mem_rdata;
            end
            if (state_q == ST_RESP_DM && resp_ld_q && !resp_err_q) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    // Responses are gated by rst so an access cut off by reset never completes.
    assign if_valid = !rst && (state_q == ST_RESP_IF);
    assign dm_valid = !rst && (state_q == ST_RESP_DM) && !resp_err_q;
    assign dm_err   = !rst && (state_q == ST_RESP_DM) && resp_err_q;

    // Read data is passed straight through in the response cycle and held after.
    assign if_rdata = rst ? 32'h0 : (if_valid ? mem_rdata : if_rdata_q);
    assign dm_rdata = rst ? 32'h0 : ((dm_valid && resp_ld_q) ? mem_rdata : dm_rdata_q);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;
  import riscv_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int MAX_STARVE = 4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_STARVE(MAX_STARVE)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_size   (dm_size),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // ---------------- memory model + shadow ----------------
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we && mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] if_exp_q[$];
  logic [33:0] dm_exp_q[$];   // {err, check_data, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] ie;
    logic [33:0] de;
    if (if_valid) begin
      if (if_exp_q.size() == 0) check("if_unexpected_valid", 64'(if_valid), 64'd0);
      else begin
        ie = if_exp_q.pop_front();
        check("if_rdata", 64'(if_rdata), 64'(ie));
      end
    end
    if (dm_valid || dm_err) begin
      if (dm_exp_q.size() == 0) check("dm_unexpected_resp", 64'({dm_err, dm_valid}), 64'd0);
      else begin
        de = dm_exp_q.pop_front();
        check("dm_err_valid", 64'({dm_err, dm_valid}), 64'({de[33], ~de[33]}));
        if (de[32]) check("dm_rdata", 64'(dm_rdata), 64'(de[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dm(input logic we, input logic [1:0] size, input logic [7:0] addr,
                          input logic [31:0] wdata);
    dm_req = 1'b1; dm_we = we; dm_size = size; dm_addr = addr; dm_wdata = wdata;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  be;
    logic [5:0]  waddr;
  } vec_t;

  vec_t vecs[12];

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 8'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = SZ_WORD; dm_addr = 8'h0; dm_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = {i[7:0], 8'hA5, 8'(i * 3), 8'h5A};
      ref_mem[i] = {i[7:0], 8'hA5, 8'(i * 3), 8'h5A};
    end
    mem[2]     = 32'h0040A183;
    ref_mem[2] = 32'h0040A183;

    vecs[0]  = '{1'b1, SZ_BYTE, 8'h0E, 32'h00AB0000, 1'b0, 4'b0100, 6'd3};
    vecs[1]  = '{1'b0, SZ_WORD, 8'h0C, 32'h0,        1'b0, 4'b1111, 6'd3};
    vecs[2]  = '{1'b1, SZ_HALF, 8'h12, 32'hBEEF0000, 1'b0, 4'b1100, 6'd4};
    vecs[3]  = '{1'b0, SZ_HALF, 8'h10, 32'h0,        1'b0, 4'b0011, 6'd4};
    vecs[4]  = '{1'b0, SZ_BYTE, 8'h07, 32'h0,        1'b0, 4'b1000, 6'd1};
    vecs[5]  = '{1'b0, SZ_WORD, 8'h06, 32'h0,        1'b1, 4'b0000, 6'd0};
    vecs[6]  = '{1'b0, 2'b11,   8'h00, 32'h0,        1'b1, 4'b0000, 6'd0};
    vecs[7]  = '{1'b1, SZ_HALF, 8'h05, 32'h5555AAAA, 1'b1, 4'b0000, 6'd0};
    vecs[8]  = '{1'b1, SZ_WORD, 8'h14, 32'hCAFEF00D, 1'b0, 4'b1111, 6'd5};
    vecs[9]  = '{1'b0, SZ_WORD, 8'h14, 32'h0,        1'b0, 4'b1111, 6'd5};
    vecs[10] = '{1'b0, SZ_HALF, 8'h03, 32'h0,        1'b1, 4'b0000, 6'd0};
    vecs[11] = '{1'b0, SZ_BYTE, 8'h02, 32'h0,        1'b0, 4'b0100, 6'd0};

    // Reset state
    step(); step();
    @(negedge clk);
    check("reset_ctrl", 64'({if_valid, dm_valid, dm_err, mem_en, mem_we, mem_be, mem_addr}), 64'd0);
    check("reset_data", 64'({if_rdata, dm_rdata}), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);

    // IF only, held for three fetches
    step();
    rst = 1'b0; if_req = 1'b1; if_addr = 8'h08;
    if_exp_q.push_back(32'h0040A183);
    @(negedge clk);
    check("if_grant0", 64'({mem_en, mem_we, mem_be, mem_addr}), 64'({1'b1, 1'b0, 4'hF, 6'd2}));
    step();
    if_addr = 8'h0C;
    if_exp_q.push_back(ref_mem[3]);
    @(negedge clk);
    check("if_latency_valid", 64'(if_valid), 64'd1);
    check("if_latency_rdata", 64'(if_rdata), 64'h0040A183);
    check("if_grant1", 64'({mem_en, mem_be, mem_addr}), 64'({1'b1, 4'hF, 6'd3}));
    step();
    if_addr = 8'h11;   // offset bits ignored
    if_exp_q.push_back(ref_mem[4]);
    @(negedge clk);
    check("if_grant2", 64'({mem_en, mem_be, mem_addr}), 64'({1'b1, 4'hF, 6'd4}));
    step();
    if_req = 1'b0;
    @(negedge clk);
    check("if_idle_no_en", 64'(mem_en), 64'd0);

    // Contention: DM x4, then IF forced, then DM resumes
    for (int i = 0; i < 6; i++) begin
      step();
      if_req = 1'b1; if_addr = 8'h08;
      drive_dm(1'b0, SZ_WORD, 8'h0C, 32'h0);
      if (i == 4) if_exp_q.push_back(ref_mem[2]);
      else        dm_exp_q.push_back({1'b0, 1'b1, ref_mem[3]});
      @(negedge clk);
      check($sformatf("contention_grant%0d", i), 64'({mem_en, mem_addr}),
            64'({1'b1, (i == 4) ? 6'd2 : 6'd3}));
    end
    step();
    if_req = 1'b0; dm_req = 1'b0;
    step();

    // Table-driven DM accesses
    for (int i = 0; i < 12; i++) begin
      step();
      drive_dm(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].err) dm_exp_q.push_back({1'b1, 1'b0, 32'h0});
      else if (vecs[i].we) dm_exp_q.push_back({1'b0, 1'b0, 32'h0});
      else dm_exp_q.push_back({1'b0, 1'b1, ref_mem[vecs[i].waddr]});
      if (vecs[i].we && !vecs[i].err) begin
        for (int b = 0; b < 4; b++) begin
          if (vecs[i].be[b]) ref_mem[vecs[i].waddr][8*b +: 8] = vecs[i].wdata[8*b +: 8];
        end
      end
      @(negedge clk);
      if (vecs[i].err)
        check($sformatf("vec%0d_rejected", i),
              64'({mem_en, mem_we, mem_be, mem_addr, mem_wdata}), 64'd0);
      else
        check($sformatf("vec%0d_mem", i), 64'({mem_en, mem_we, mem_be, mem_addr}),
              64'({1'b1, vecs[i].we, vecs[i].be, vecs[i].waddr}));
      if (vecs[i].we && !vecs[i].err)
        check($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].wdata));
      step();
      dm_req = 1'b0;
      @(negedge clk);
      if (vecs[i].err) check($sformatf("vec%0d_no_valid", i), 64'(dm_valid), 64'd0);
    end
    check("store_byte_lane2", 64'(mem[3][23:16]), 64'hAB);

    // Write-then-read back-to-back
    step();
    drive_dm(1'b1, SZ_WORD, 8'h0C, 32'h12345678);
    dm_exp_q.push_back({1'b0, 1'b0, 32'h0});
    @(negedge clk);
    check("wr_grant", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b1, 6'd3}));
    step();
    dm_we = 1'b0;
    dm_exp_q.push_back({1'b0, 1'b1, 32'h12345678});
    @(negedge clk);
    check("rd_grant", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b0, 6'd3}));
    step();
    dm_req = 1'b0;
    @(negedge clk);
    check("wr_rd_data", 64'(dm_rdata), 64'h12345678);
    ref_mem[3] = 32'h12345678;

    // Reset mid-access with a partly built starve count
    for (int k = 0; k < 3; k++) begin
      step();
      if_req = 1'b1; if_addr = 8'h08;
      drive_dm(1'b0, SZ_WORD, 8'h0C, 32'h0);
      if (k < 2) dm_exp_q.push_back({1'b0, 1'b1, 32'h12345678});
      @(negedge clk);
      check($sformatf("pre_rst_grant%0d", k), 64'({mem_en, mem_addr}), 64'({1'b1, 6'd3}));
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mem", 64'({mem_en, mem_we, mem_be, mem_addr, mem_wdata}), 64'd0);
    check("rst_mid_resp", 64'({dm_valid, if_valid, dm_err}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      rst = 1'b0;
      if (i == 4) if_exp_q.push_back(ref_mem[2]);
      else        dm_exp_q.push_back({1'b0, 1'b1, 32'h12345678});
      @(negedge clk);
      check($sformatf("post_rst_grant%0d", i), 64'({mem_en, mem_addr}),
            64'({1'b1, (i == 4) ? 6'd2 : 6'd3}));
    end
    step();
    if_req = 1'b0; dm_req = 1'b0;
    step(); step();
    @(negedge clk);

    check("if_queue_drained", 64'(if_exp_q.size()), 64'd0);
    check("dm_queue_drained", 64'(dm_exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported, synchronous-read unified memory between the instruction-fetch port and the load/store port of the core.
- Replaces the separate combinational instruction and data memories.
- Grants one access per cycle with data-over-fetch priority and a bounded-starvation guarantee for fetch.
- Generates byte enables and flags misaligned data accesses.

Parameters:
- ADDR_W, 8, byte-address width of both requester ports; memory word address is ADDR_W-2 bits (64 words at default).
- MAX_STARVE, 4, consecutive cycles fetch may be denied while requesting before it is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored)
- if_rdata  out  32  fetched word, valid with if_valid
- if_valid  out  1  one-cycle pulse: fetch completed
- dm_req  in  1  data request, level, held until dm_valid or dm_err
- dm_we  in  1  1 = store, 0 = load
- dm_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  32  store data, already lane-aligned
- dm_rdata  out  32  raw loaded word (no extension), valid with dm_valid
- dm_valid  out  1  one-cycle pulse: data access completed
- dm_err  out  1  one-cycle pulse: misaligned or illegal-size request rejected
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, one cycle after mem_en

Behaviour:
- Clocking: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all outputs 0; state IDLE; starve counter 0. All mem_* outputs are forced 0 during any cycle with rst=1, including reset asserted mid-access; a pending response is discarded.
- States: IDLE (no outstanding access), RESP_IF, RESP_DM.
- Grant logic (combinational, evaluated in every state):
  - dm_req only -> DM.
  - if_req only -> IF.
  - Both requesting: DM, unless the starve counter equals MAX_STARVE, in which case IF.
  - Granted access drives mem_en=1 in that cycle.
- Next state: RESP_IF or RESP_DM per grant; IDLE if nothing is granted.
- Response timing:
  - In RESP_x, x_valid=1 for exactly one cycle; x_rdata = mem_rdata, registered and held until the next valid for that port.
  - Latency is request-to-valid = 1 cycle when granted immediately.
  - Back-to-back grants are allowed: a request present during a RESP cycle, including the same port's req still high, is treated as a NEW request and may be granted that cycle.
- Starve counter:
  - Increments (saturating at MAX_STARVE) each cycle if_req=1 and DM is granted.
  - Clears on any IF grant, and when if_req=0.
- DM byte-enable / alignment:
  - byte: be = 0001 << addr[1:0].
  - half: addr[0] must be 0; be = 0011 << addr[1:0].
  - word: addr[1:0] must be 00; be = 1111.
  - Misaligned access or size 11: no grant and no mem_en; dm_err pulses the next cycle; counts as a DM slot for arbitration (fetch loses that cycle).
- Loads: mem_we=0, mem_be still driven per size.
- Stores: mem_we=1, mem_wdata = dm_wdata; dm_valid pulses next cycle (write completion).
- IF accesses: mem_we=0, mem_be=1111, mem_addr = if_addr[ADDR_W-1:2].
- mem_addr for DM: dm_addr[ADDR_W-1:2].

Decomposition:
- Shared package (riscv_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - arbiter state enum.
- Sub-module be_gen: combinational size+offset -> mem_be and misalign flag; reused later by the load/store unit.
- Arbiter FSM, starve counter and response registers stay in the top.

Test Plan:
- IF only: if_req=1, if_addr=0x08, mem word 2 = 0x0040A183 -> cycle 1 mem_en=1, mem_addr=2; cycle 2 if_valid=1, if_rdata=0x0040A183; fetching continues every cycle with if_req held.
- Contention: if_req and dm_req held high with dm_addr=0x0C, dm_we=0 -> DM granted 4 consecutive cycles, 5th cycle IF granted (starve=MAX_STARVE), then DM resumes; no port waits >5 cycles.
- Store byte: dm_we=1, dm_size=00, dm_addr=0x0E, dm_wdata=0x00AB0000 -> mem_we=1, mem_be=0100, mem_addr=3; dm_valid next cycle; word 3 lane 2 = 0xAB.
- Misaligned: dm_size=10, dm_addr=0x06 -> mem_en=0, dm_err=1 next cycle, dm_valid=0; same with dm_size=11, dm_addr=0x00.
- Reset mid-access: grant DM load at cycle N, rst=1 at N+1 -> dm_valid=0, all mem_* 0 during reset, state IDLE, starve counter 0 after release.
- Write-then-read: sw 0x12345678 to 0x0C, then lw 0x0C back-to-back -> dm_rdata=0x12345678 two cycles after the store grant.
